// File: rtl/ibex_microarchtrace_pkg.sv
// Shared types for the micro-architectural trace FIFO: record kind codes,
// input event codes, default record layout and a record-width helper.
// Purely declarative; no logic, no latency, no flow control.
package ibex_microarchtrace_pkg;

    // Kind field stored in the top 3 bits of every record.
    typedef enum logic [2:0] {
        KIND_IF              = 3'd0,
        KIND_IF_START        = 3'd1,
        KIND_IF_END          = 3'd2,
        KIND_IDEX            = 3'd3,
        KIND_IDEX_MULT_START = 3'd4,
        KIND_IDEX_MULT_END   = 3'd5,
        KIND_OVERFLOW        = 3'd7
    } trace_kind_e;

    // Fetch-side event codes as presented on if_evt_kind.
    localparam logic [1:0] IF_KIND_IF    = 2'd0;
    localparam logic [1:0] IF_KIND_START = 2'd1;
    localparam logic [1:0] IF_KIND_END   = 2'd2;

    // ID/EX-side event codes as presented on idex_evt_kind.
    localparam logic [1:0] IDEX_KIND_IDEX       = 2'd0;
    localparam logic [1:0] IDEX_KIND_MULT_START = 2'd1;
    localparam logic [1:0] IDEX_KIND_MULT_END   = 2'd2;

    // Code 3 on either event input is not a real event.
    localparam logic [1:0] EVT_KIND_ILLEGAL = 2'd3;

    // Default timestamp width; the top level may override it per instance.
    localparam int TRACE_TS_W = 32;

    // Record layout at the default timestamp width, MSB first.
    typedef struct packed {
        trace_kind_e           kind;
        logic [TRACE_TS_W-1:0] ts;
        logic [31:0]           pc;
        logic [31:0]           insn;
        logic [1:0]            mode;
        logic                  c;
    } trace_rec_t;

    // kind(3) + pc(32) + insn(32) + mode(2) + c(1) + timestamp.
    function automatic int rec_w(input int ts_w);
        return 70 + ts_w;
    endfunction

endpackage

// File: rtl/ibex_microarchtrace_fifo_mem.sv
// Record storage: two write ports at wr_ptr and wr_ptr+1, one async read port.
// Latency: writes land on the clock edge, read is combinational (fall-through).
// No flow control here; the caller guarantees writes only go to free slots.
//
// Ports: clk; we0/wdata0 write slot wr_ptr; we1/wdata1 write slot wr_ptr+1;
//        rd_ptr/rdata combinational read. Contents are never reset.
module ibex_microarchtrace_fifo_mem #(
    parameter int  DEPTH = 64,
    parameter int  W     = 102,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic          we1,
    input  logic [PW-1:0] wr_ptr,
    input  logic [W-1:0]  wdata0,
    input  logic [W-1:0]  wdata1,
    input  logic [PW-1:0] rd_ptr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr1;

    // DEPTH is a power of two, so the +1 wraps naturally.
    assign wr_ptr1 = wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (we0) begin
            mem[wr_ptr] <= wdata0;
        end
        if (we1) begin
            mem[wr_ptr1] <= wdata1;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ibex_microarchtrace_fifo.sv
// Timestamps fetch and ID/EX trace events and queues them as packed records.
// Latency: an accepted event is visible at out_data the cycle after sampling.
// Backpressure: out_valid/out_ready pop; on lack of space events are dropped
// and counted, and an OVERFLOW record carrying the count is queued later.
//
// Ports: clk, rst_n (synchronous active-low); trace_en gates capture;
//        if_* fetch event, idex_* ID/EX event; out_valid/out_ready/out_data
//        head record; level occupancy; drop_pending overflow marker owed.
// Optional: IBEX_MICROARCHTRACE_FIFO_HWM_EN adds level_max (high-water mark).
module ibex_microarchtrace_fifo
    import ibex_microarchtrace_pkg::*;
#(
    parameter int  DEPTH = 64,
    parameter int  TS_W  = 32,
    localparam int REC_W = rec_w(TS_W),
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trace_en,
    input  logic             if_evt_valid,
    input  logic [1:0]       if_evt_kind,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_insn,
    input  logic [1:0]       if_mode,
    input  logic             if_c,
    input  logic             idex_evt_valid,
    input  logic [1:0]       idex_evt_kind,
    input  logic [31:0]      idex_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic             drop_pending
`ifdef IBEX_MICROARCHTRACE_FIFO_HWM_EN
    ,
    output logic [LW-1:0]    level_max
`endif
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [TS_W-1:0] ts_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [31:0]     drop_cnt_q;

    // ------------------------------------------------------------------
    // Candidate records
    // ------------------------------------------------------------------
    trace_kind_e      if_kind;
    trace_kind_e      idex_kind;
    logic [REC_W-1:0] ovf_rec;
    logic [REC_W-1:0] if_rec;
    logic [REC_W-1:0] idex_rec;

    always_comb begin
        if_kind = KIND_IF;
        case (if_evt_kind)
            IF_KIND_START: if_kind = KIND_IF_START;
            IF_KIND_END:   if_kind = KIND_IF_END;
            default:       if_kind = KIND_IF;
        endcase
    end

    always_comb begin
        idex_kind = KIND_IDEX;
        case (idex_evt_kind)
            IDEX_KIND_MULT_START: idex_kind = KIND_IDEX_MULT_START;
            IDEX_KIND_MULT_END:   idex_kind = KIND_IDEX_MULT_END;
            default:              idex_kind = KIND_IDEX;
        endcase
    end

    // The overflow marker reports the drop count accumulated so far in its pc field.
    assign ovf_rec  = {KIND_OVERFLOW, ts_q, drop_cnt_q, 32'h0, 2'b00, 1'b0};
    assign idex_rec = {idex_kind, ts_q, idex_pc, 32'h0, 2'b00, 1'b0};

    // IF_START only marks the start of a fetch; its payload carries nothing.
    assign if_rec = (if_evt_kind == IF_KIND_START)
                  ? {KIND_IF_START, ts_q, 32'h0, 32'h0, 2'b00, 1'b0}
                  : {if_kind, ts_q, if_pc, if_insn, if_mode, if_c};

    // ------------------------------------------------------------------
    // Slot allocation
    // ------------------------------------------------------------------
    logic          mark_c;
    logic          idex_c;
    logic          if_c_evt;
    logic [LW-1:0] free;
    logic [1:0]    cap;
    logic [1:0]    n_push;
    logic [1:0]    n_drop;
    logic          mark_wr;
    logic          idex_wr;
    logic          if_wr;

    assign mark_c   = (drop_cnt_q != 32'h0);
    assign idex_c   = trace_en && idex_evt_valid && (idex_evt_kind != EVT_KIND_ILLEGAL);
    assign if_c_evt = trace_en && if_evt_valid && (if_evt_kind != EVT_KIND_ILLEGAL);

    // Free space ignores a same-cycle pop so the write path never depends
    // on out_ready. At most two slots are written per cycle.
    assign free = DEPTH_L - level_q;
    assign cap  = (free >= LW'(2)) ? 2'd2 : free[1:0];

    // Priority: marker, then ID/EX, then fetch. The marker never counts as a drop.
    always_comb begin
        n_push  = 2'd0;
        n_drop  = 2'd0;
        mark_wr = 1'b0;
        idex_wr = 1'b0;
        if_wr   = 1'b0;
        if (mark_c && (n_push < cap)) begin
            mark_wr = 1'b1;
            n_push  = n_push + 2'd1;
        end
        if (idex_c) begin
            if (n_push < cap) begin
                idex_wr = 1'b1;
                n_push  = n_push + 2'd1;
            end else begin
                n_drop = n_drop + 2'd1;
            end
        end
        if (if_c_evt) begin
            if (n_push < cap) begin
                if_wr  = 1'b1;
                n_push = n_push + 2'd1;
            end else begin
                n_drop = n_drop + 2'd1;
            end
        end
    end

    // Slot 0 takes the highest-priority written record, slot 1 the next one.
    logic             we0;
    logic             we1;
    logic [REC_W-1:0] wdata0;
    logic [REC_W-1:0] wdata1;

    assign we0    = (n_push != 2'd0);
    assign we1    = (n_push == 2'd2);
    assign wdata0 = mark_wr ? ovf_rec : (idex_wr ? idex_rec : if_rec);
    assign wdata1 = (mark_wr && idex_wr) ? idex_rec : if_rec;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic          pop;
    logic [LW-1:0] level_nxt;
    logic [32:0]   drop_sum;
    logic [31:0]   drop_nxt;

    assign pop       = (level_q != '0) && out_ready;
    assign level_nxt = level_q + LW'(n_push) - LW'(pop);

    // Once the marker is written the old count is reported; restart from
    // whatever was dropped in that same cycle.
    assign drop_sum = {1'b0, (mark_wr ? 32'h0 : drop_cnt_q)} + 33'(n_drop);
    assign drop_nxt = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            wr_ptr_q   <= wr_ptr_q + PW'(n_push);
            rd_ptr_q   <= rd_ptr_q + PW'(pop);
            level_q    <= level_nxt;
            drop_cnt_q <= drop_nxt;
        end
    end

`ifdef IBEX_MICROARCHTRACE_FIFO_HWM_EN
    logic [LW-1:0] level_max_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_max_q <= '0;
        end else if (level_nxt > level_max_q) begin
            level_max_q <= (level_nxt > DEPTH_L) ? DEPTH_L : level_nxt;
        end
    end

    assign level_max = level_max_q;
`endif

    // ------------------------------------------------------------------
    // Storage and outputs
    // ------------------------------------------------------------------
    ibex_microarchtrace_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .we1    (we1),
        .wr_ptr (wr_ptr_q),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rd_ptr (rd_ptr_q),
        .rdata  (out_data)
    );

    assign out_valid    = (level_q != '0);
    assign level        = level_q;
    assign drop_pending = (drop_cnt_q != 32'h0);

endmodule

// File: tb/tb_ibex_microarchtrace_fifo.sv
module tb_ibex_microarchtrace_fifo;
    import ibex_microarchtrace_pkg::*;

    localparam int DEPTH   = 64;
    localparam int REC     = 102;
    localparam int DEPTH_B = 4;
    localparam int REC_B   = 74;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic        if_evt_valid;
    logic [1:0]  if_evt_kind;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic [1:0]  if_mode;
    logic        if_c;
    logic        idex_evt_valid;
    logic [1:0]  idex_evt_kind;
    logic [31:0] idex_pc;
    logic        out_ready;
    logic        out_ready_b;

    logic             out_valid_a;
    logic [REC-1:0]   out_data_a;
    logic [6:0]       level_a;
    logic             drop_pending_a;
    logic             out_valid_b;
    logic [REC_B-1:0] out_data_b;
    logic [2:0]       level_b;
    logic             drop_pending_b;
`ifdef IBEX_MICROARCHTRACE_FIFO_HWM_EN
    logic [6:0]       level_max_a;
    logic [2:0]       level_max_b;
`endif

    always #5 clk = ~clk;

    ibex_microarchtrace_fifo #(.DEPTH(DEPTH), .TS_W(32)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .trace_en       (trace_en),
        .if_evt_valid   (if_evt_valid),
        .if_evt_kind    (if_evt_kind),
        .if_pc          (if_pc),
        .if_insn        (if_insn),
        .if_mode        (if_mode),
        .if_c           (if_c),
        .idex_evt_valid (idex_evt_valid),
        .idex_evt_kind  (idex_evt_kind),
        .idex_pc        (idex_pc),
        .out_valid      (out_valid_a),
        .out_ready      (out_ready),
        .out_data       (out_data_a),
        .level          (level_a),
`ifdef IBEX_MICROARCHTRACE_FIFO_HWM_EN
        .level_max      (level_max_a),
`endif
        .drop_pending   (drop_pending_a)
    );

    // Narrow-timestamp instance, always drained, used for wrap checks.
    ibex_microarchtrace_fifo #(.DEPTH(DEPTH_B), .TS_W(4)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .trace_en       (trace_en),
        .if_evt_valid   (if_evt_valid),
        .if_evt_kind    (if_evt_kind),
        .if_pc          (if_pc),
        .if_insn        (if_insn),
        .if_mode        (if_mode),
        .if_c           (if_c),
        .idex_evt_valid (idex_evt_valid),
        .idex_evt_kind  (idex_evt_kind),
        .idex_pc        (idex_pc),
        .out_valid      (out_valid_b),
        .out_ready      (out_ready_b),
        .out_data       (out_data_b),
        .level          (level_b),
`ifdef IBEX_MICROARCHTRACE_FIFO_HWM_EN
        .level_max      (level_max_b),
`endif
        .drop_pending   (drop_pending_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of expected records plus a drop counter.
    // ------------------------------------------------------------------
    logic [REC-1:0] q[$];
    logic [31:0]    m_ts;
    logic [31:0]    m_drop;
    bit             started = 0;

    function automatic logic [REC-1:0] mk(input logic [2:0] k, input logic [31:0] ts,
                                          input logic [31:0] pc, input logic [31:0] insn,
                                          input logic [1:0] mode, input logic c);
        return {k, ts, pc, insn, mode, c};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ts    = 0;
            m_drop  = 0;
            started = 1;
        end else if (started) begin
            int unsigned free, slots, n, drops, sz;
            bit          marked;
            logic [REC-1:0] r;
            sz     = q.size();
            free   = DEPTH - sz;
            slots  = (free < 2) ? free : 2;
            n      = 0;
            drops  = 0;
            marked = 0;
            if (m_drop != 0 && n < slots) begin
                q.push_back(mk(3'd7, m_ts, m_drop, 0, 0, 0));
                n++;
                marked = 1;
            end
            if (trace_en && idex_evt_valid && idex_evt_kind != 2'd3) begin
                if (n < slots) begin
                    q.push_back(mk(3'(idex_evt_kind) + 3'd3, m_ts, idex_pc, 0, 0, 0));
                    n++;
                end else begin
                    drops++;
                end
            end
            if (trace_en && if_evt_valid && if_evt_kind != 2'd3) begin
                if (n < slots) begin
                    if (if_evt_kind == 2'd1) r = mk(3'd1, m_ts, 0, 0, 0, 0);
                    else r = mk(3'(if_evt_kind), m_ts, if_pc, if_insn, if_mode, if_c);
                    q.push_back(r);
                    n++;
                end else begin
                    drops++;
                end
            end
            if (out_ready && sz > 0) void'(q.pop_front());
            begin
                longint unsigned s;
                s = (marked ? 0 : longint'(m_drop)) + drops;
                m_drop = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            end
            m_ts = m_ts + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid_a, q.size() != 0);
            chk("level", level_a, q.size());
            chk("drop_pending", drop_pending_a, m_drop != 0);
            if (q.size() != 0) chk("out_data", out_data_a, q[0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic iv, input logic [1:0] ik, input logic [31:0] ipc,
                         input logic fv, input logic [1:0] fk, input logic [31:0] fpc,
                         input logic [31:0] finsn, input logic [1:0] fmode, input logic fc,
                         input logic rdy);
        idex_evt_valid = iv;
        idex_evt_kind  = ik;
        idex_pc        = ipc;
        if_evt_valid   = fv;
        if_evt_kind    = fk;
        if_pc          = fpc;
        if_insn        = finsn;
        if_mode        = fmode;
        if_c           = fc;
        out_ready      = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    trace_rec_t  r;
    logic [31:0] t1, t2;
    logic [3:0]  b1, b2;

    initial begin
        rst_n = 1'b0; trace_en = 1'b1; out_ready_b = 1'b1;
        idex_evt_valid = 0; idex_evt_kind = 0; idex_pc = 0;
        if_evt_valid = 0; if_evt_kind = 0; if_pc = 0; if_insn = 0; if_mode = 0; if_c = 0;
        out_ready = 0;
        @(negedge clk);
        idle(0);
        idle(0);
        chk("reset_level", level_a, 7'd0);
        chk("reset_valid", out_valid_a, 1'b0);
        chk("reset_drop", drop_pending_a, 1'b0);

        // First event right after reset carries ts 0.
        rst_n = 1'b1;
        drive(1, 2'd0, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        r = out_data_a;
        chk("first_kind", r.kind, 3'd3);
        chk("first_pc", r.pc, 32'h80);
        chk("first_ts", r.ts, 32'd0);
        chk("first_level", level_a, 7'd1);

        // Dual push: ID/EX record ahead of fetch record, same timestamp.
        drive(1, 2'd1, 32'hFC, 1, 2'd0, 32'h100, 32'h13, 2'd3, 1'b0, 1);
        r = out_data_a;
        chk("dual_level", level_a, 7'd2);
        chk("dual0_kind", r.kind, 3'd4);
        chk("dual0_pc", r.pc, 32'hFC);
        chk("dual0_ts", r.ts, 32'd1);
        idle(1);
        r = out_data_a;
        chk("dual1_kind", r.kind, 3'd0);
        chk("dual1_pc", r.pc, 32'h100);
        chk("dual1_insn", r.insn, 32'h13);
        chk("dual1_mode", r.mode, 2'd3);
        chk("dual1_ts", r.ts, 32'd1);
        idle(1);

        // Fill, overflow by three, then let the marker in.
        for (int i = 0; i < DEPTH + 3; i++) drive(1, 2'd0, 32'h1000 + i, 0, 0, 0, 0, 0, 0, 0);
        chk("full_level", level_a, 7'd64);
        chk("full_drop", drop_pending_a, 1'b1);
        idle(1);
        chk("pop_full_level", level_a, 7'd63);
        chk("pop_full_drop", drop_pending_a, 1'b1);
        idle(0);
        chk("marker_level", level_a, 7'd64);
        chk("marker_drop", drop_pending_a, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) idle(1);
        r = out_data_a;
        chk("marker_kind", r.kind, 3'd7);
        chk("marker_pc", r.pc, 32'd3);
        chk("marker_left", level_a, 7'd1);
        idle(1);

        // Full with simultaneous pop and push: the push is still dropped.
        for (int i = 0; i < DEPTH; i++) drive(1, 2'd2, 32'h2000 + i, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 2'd0, 32'h3000, 0, 0, 0, 0, 0, 0, 1);
        chk("fullpop_level", level_a, 7'd63);
        chk("fullpop_drop", drop_pending_a, 1'b1);
        idle(0);
        for (int i = 0; i < DEPTH + 2; i++) idle(1);

        // Capture disabled and illegal kinds: nothing queued, nothing dropped.
        trace_en = 1'b0;
        drive(1, 2'd0, 32'h44, 1, 2'd2, 32'h48, 32'h1, 2'd0, 1'b1, 1);
        trace_en = 1'b1;
        drive(1, 2'd3, 32'h50, 1, 2'd3, 32'h54, 32'h1, 2'd0, 1'b1, 1);
        chk("gated_level", level_a, 7'd0);
        chk("gated_drop", drop_pending_a, 1'b0);
        drive(0, 0, 0, 1, 2'd1, 32'h60, 32'h99, 2'd3, 1'b1, 0);
        r = out_data_a;
        chk("ifstart_pc", r.pc, 32'd0);
        chk("ifstart_kind", r.kind, 3'd1);
        idle(1);

        // Mixed traffic under light draining, checked by the model.
        for (int i = 0; i < 400; i++) begin
            trace_en = ($urandom_range(0, 7) != 0);
            drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom,
                  $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 3));
        end
        trace_en = 1'b1;

        // Reset mid-drain discards the queue and restarts the timestamp.
        for (int i = 0; i < DEPTH + 4; i++) idle(1);
        for (int i = 0; i < 10; i++) drive(1, 2'd0, 32'h500 + i, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_level", level_a, 7'd10);
        rst_n = 1'b0;
        drive(1, 2'd0, 32'h600, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 2'd0, 32'h604, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_level", level_a, 7'd0);
        chk("rst_valid", out_valid_a, 1'b0);
        rst_n = 1'b1;
        drive(1, 2'd0, 32'h44, 0, 0, 0, 0, 0, 0, 1);
        r = out_data_a;
        chk("rst_ts", r.ts, 32'd0);
        chk("rst_pc", r.pc, 32'h44);

        // 4-bit timestamp wrap: events 17 cycles apart.
        for (int i = 0; i < 4; i++) idle(1);
        t1 = m_ts;
        drive(1, 2'd0, 32'h700, 0, 0, 0, 0, 0, 0, 1);
        b1 = out_data_b[70:67];
        chk("tsw_valid1", out_valid_b, 1'b1);
        chk("tsw_ts1", b1, t1[3:0]);
        for (int i = 0; i < 16; i++) idle(1);
        t2 = m_ts;
        drive(1, 2'd0, 32'h704, 0, 0, 0, 0, 0, 0, 1);
        b2 = out_data_b[70:67];
        chk("tsw_valid2", out_valid_b, 1'b1);
        chk("tsw_ts2", b2, t2[3:0]);
        chk("tsw_gap", 4'(b2 - b1), 4'd1);
        idle(1);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_microarchtrace_fifo.md
Name: ibex_microarchtrace_fifo

Overview:
Downstream consumer of the ibex micro-architectural trace monitor events. Accepts up to two event strobes per cycle: one fetch event and one ID/EX event. Each accepted event is timestamped, packed into a fixed-width record and queued in a dual-push, single-pop FIFO. Records drain through a valid/ready port to a debug streamer or memory writer. This replaces the DPI sink on FPGA/silicon builds.

Parameters:
DEPTH, 64, FIFO entries; power of two, >= 4
TS_W, 32, timestamp counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
trace_en  in  1  capture enable; events ignored when 0; timestamp keeps running
if_evt_valid  in  1  fetch event strobe
if_evt_kind  in  2  0=IF, 1=IF_START, 2=IF_END; 3 is illegal and ignored
if_pc  in  32  fetch PC
if_insn  in  32  fetched instruction (decompressed)
if_mode  in  2  privilege mode
if_c  in  1  compressed flag
idex_evt_valid  in  1  ID/EX event strobe
idex_evt_kind  in  2  0=IDEX, 1=IDEX_MULT_START, 2=IDEX_MULT_END; 3 is illegal and ignored
idex_pc  in  32  ID/EX PC
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head
out_data  out  REC_W  head record; REC_W = 70+TS_W
level  out  $clog2(DEPTH)+1  current occupancy
drop_pending  out  1  overflow marker is owed

Behaviour:
- Record layout, MSB to LSB: kind[2:0], ts[TS_W-1:0], pc[31:0], insn[31:0], mode[1:0], c.
- kind codes: IF=0, IF_START=1, IF_END=2, IDEX=3, IDEX_MULT_START=4, IDEX_MULT_END=5, OVERFLOW=7.
- IDEX records: insn, mode and c fields are 0.
- IF_START records: pc, insn, mode and c fields are 0.
- OVERFLOW record: pc field = drop count; other payload fields 0.
- Timestamp counter:
  - 0 at reset; +1 every cycle; wraps modulo 2^TS_W.
  - A record carries the counter value of the cycle its event was sampled.
  - The OVERFLOW record carries the counter value of the cycle it is written.
- Push order within one cycle: pending OVERFLOW marker, then IDEX event, then IF event. Entries are written to consecutive slots.
- Free space = DEPTH - level, using the registered level only. A same-cycle pop is not credited.
- Slot allocation: candidates are taken in push order while free space remains. Candidates that do not fit are dropped.
- Drop count register (32-bit, saturates at 0xFFFFFFFF):
  - If the marker was written this cycle, drop count <= drops this cycle.
  - Otherwise, drop count <= drop count + drops this cycle.
- drop_pending = (drop count != 0).
- Pop: on out_valid && out_ready, head advances by one.
- out_valid = (level != 0); out_data = mem[rd_ptr], first-word fall-through.
- level next = level + pushes - pop. Maximum push is 2 per cycle (marker + IDEX with IF dropped, or IDEX + IF).
  - Three candidates with free >= 3 is still capped at 2 pushes; the IF event is dropped and counted.
- Pointers: $clog2(DEPTH) bits, wrap naturally.
- Full: level == DEPTH. Nothing is written, all candidates count as drops, pop still allowed.
- Empty: out_valid = 0; out_data is don't-care but stable.
- trace_en = 0 mid-stream: queued records still drain; new events neither pushed nor counted as drops.
- Reset: synchronous, takes effect on the next rising edge.
  - Clears pointers, level, timestamp and drop count.
  - out_valid = 0, level = 0, drop_pending = 0.
  - Memory contents are not reset.
  - A reset mid-drain discards all queued records.
- Illegal kind: treated as no event; no record, no drop.

Optional Feature:
IBEX_MICROARCHTRACE_FIFO_HWM_EN
- Defined: adds output port level_max ($clog2(DEPTH)+1 bits).
  - Highest level since reset; updated with level next; reset 0.
  - Saturates at DEPTH.
- Undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package ibex_microarchtrace_pkg holds:
  - trace_kind_e enum (3-bit codes above)
  - if_kind / idex_kind input codes
  - trace_rec_t packed struct, parameterised via TS_W localparam default 32
  - REC_W helper function
- Sub-module ibex_microarchtrace_fifo_mem: dual-write-port, single-read-port register array with write enables we0/we1 at wr_ptr and wr_ptr+1, combinational read.
- Top level holds the allocation logic, counters and timestamp.

Test Plan:
- Reset, then IDEX at pc=0x80 while trace_en=1 -> next cycle out_valid=1, kind=3, pc=0x80, ts=0 if sampled on the first post-reset cycle; level=1.
- Same-cycle IF (pc=0x100, insn=0x00000013, mode=3, c=0) and IDEX_MULT_START (pc=0xFC) -> two records, IDEX first (kind=4, pc=0xFC), then IF (kind=0); both carry the same ts; level=2.
- out_ready=0; fill DEPTH=64 with single IDEX events, then send 3 more -> level=64, drop_pending=1. Drain one, next event idle -> OVERFLOW record written with pc=3, drop_pending=0.
- Full FIFO plus simultaneous pop and push -> push dropped (registered level rule), level=63, drop count +1.
- Reset asserted with level=10 and out_ready toggling -> following cycle level=0, out_valid=0, timestamp restarts at 0.
- Timestamp with TS_W=4: events 17 cycles apart -> second ts equals (first+17) mod 16.
